// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
// Holds the scan FSM states, the key index mapping and the parameter floors.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE
    } scan_state_e;

    // Two synchroniser flops plus one cycle of margin before a row is sampled.
    localparam int MIN_SETTLE   = 3;
    localparam int MIN_DEBOUNCE = 1;

    function automatic int key_index(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Pin and event bundle between the keypad scanner and its surroundings.
// The master side is the scanner; the slave side is the board plus game logic.
interface keypad_matrix_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int NKEYS = ROWS * COLS;

    logic             scan_en;
    logic [COLS-1:0]  kp_col;
    logic [ROWS-1:0]  kp_row;
    logic [NKEYS-1:0] key_state;
    logic [NKEYS-1:0] key_press;
    logic [NKEYS-1:0] key_release;
    logic             any_key;
    logic             frame_done;

    modport master (
        input  scan_en,
        input  kp_col,
        output kp_row,
        output key_state,
        output key_press,
        output key_release,
        output any_key,
        output frame_done
    );

    modport slave (
        output scan_en,
        output kp_col,
        input  kp_row,
        input  key_state,
        input  key_press,
        input  key_release,
        input  any_key,
        input  frame_done
    );

endinterface

// File: rtl/keypad_matrix_scanner_debounce_cell.sv
// Per-key debouncer: one state bit, a run counter of disagreeing samples,
// and registered one-cycle press/release pulses.
module keypad_debounce_cell
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic sample_en,
    input  logic raw,
    output logic state,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    if (DEBOUNCE < MIN_DEBOUNCE) begin : g_bad_debounce
        $error("DEBOUNCE must be at least %0d", MIN_DEBOUNCE);
    end

    logic [CNT_W-1:0] cnt;
    logic             flip;

    assign flip = sample_en && (raw != state) && (cnt == CNT_W'(DEBOUNCE - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= 1'b0;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            // Pulses are recomputed every cycle, so they drop after one cycle.
            press_pulse   <= flip && !state;
            release_pulse <= flip && state;
            if (sample_en) begin
                if (raw == state) begin
                    cnt <= '0;
                end else if (flip) begin
                    state <= ~state;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-at-a-time scanner for an active-low ROWS x COLS key matrix with
// synchronised columns, per-key debouncing and press/release events.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int DEBOUNCE      = 3
) (
    input  logic clock,
    input  logic reset,
    keypad_matrix_scanner_if.master bus
);

    localparam int NKEYS = ROWS * COLS;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES);

    if (ROWS < 1 || COLS < 1) begin : g_bad_dims
        $error("ROWS and COLS must both be at least 1");
    end
    if (SETTLE_CYCLES < MIN_SETTLE) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least %0d", MIN_SETTLE);
    end

    logic [COLS-1:0]  sync_meta;
    logic [COLS-1:0]  sync_col;
    logic [COLS-1:0]  raw_press;

    scan_state_e      state, state_next;
    logic [ROW_W-1:0] row_idx, row_next;
    logic [SET_W-1:0] settle_cnt, settle_next;
    logic [ROWS-1:0]  kp_row_q, kp_row_next;
    logic             frame_done_q;
    logic             last_row;

    logic [NKEYS-1:0] key_state_w;
    logic [NKEYS-1:0] key_press_w;
    logic [NKEYS-1:0] key_release_w;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the 2-flop chain relies on it).
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_meta <= '1;
            sync_col  <= '1;
        end else begin
            sync_meta <= bus.kp_col;
            sync_col  <= sync_meta;
        end
    end

    assign raw_press = ~sync_col;
    assign last_row  = (row_idx == ROW_W'(ROWS - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            row_idx      <= '0;
            settle_cnt   <= '0;
            kp_row_q     <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_next;
            row_idx      <= row_next;
            settle_cnt   <= settle_next;
            kp_row_q     <= kp_row_next;
            frame_done_q <= (state == SAMPLE) && last_row;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        row_next    = row_idx;
        settle_next = settle_cnt;
        unique case (state)
            IDLE: begin
                if (bus.scan_en) begin
                    state_next  = DRIVE;
                    row_next    = '0;
                    settle_next = '0;
                end
            end
            DRIVE: begin
                if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_next = SAMPLE;
                end else begin
                    settle_next = settle_cnt + SET_W'(1);
                end
            end
            SAMPLE: begin
                settle_next = '0;
                if (!last_row) begin
                    row_next   = row_idx + ROW_W'(1);
                    state_next = DRIVE;
                end else if (bus.scan_en) begin
                    row_next   = '0;
                    state_next = DRIVE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Row pins are registered from the next state so they never glitch.
        kp_row_next = (state_next == IDLE) ? '1 : ~(ROWS'(1) << row_next);
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int IDX = key_index(r, c, COLS);
            keypad_debounce_cell #(
                .DEBOUNCE (DEBOUNCE)
            ) u_cell (
                .clock         (clock),
                .reset         (reset),
                .sample_en     ((state == SAMPLE) && (row_idx == ROW_W'(r))),
                .raw           (raw_press[c]),
                .state         (key_state_w[IDX]),
                .press_pulse   (key_press_w[IDX]),
                .release_pulse (key_release_w[IDX])
            );
        end
    end

    assign bus.kp_row      = kp_row_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.key_state   = key_state_w;
    assign bus.key_press   = key_press_w;
    assign bus.key_release = key_release_w;
    assign bus.any_key     = |key_state_w;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench: a physical keypad model drives the columns, a frame-level
// debounce model predicts each frame's outcome, and a monitor checks it at frame_done.
module tb_keypad_matrix_scanner;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int SETTLE = 4;
    localparam int DEB    = 3;
    localparam int NK     = ROWS * COLS;
    localparam int PERIOD = ROWS * (SETTLE + 1);

    typedef logic [NK-1:0] keys_t;
    typedef struct packed {
        keys_t state;
        keys_t press;
        keys_t rel;
    } frame_exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    keypad_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    keypad_matrix_scanner #(
        .ROWS          (ROWS),
        .COLS          (COLS),
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE      (DEB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    keys_t      pressed     = '0;
    keys_t      hist[$];
    keys_t      model_state = '0;
    frame_exp_t exp_q[$];
    int         press_cyc[NK];

    always @(posedge clock) cyc <= cyc + 1;

    // Physical matrix: a held key pulls its column low while its row is driven.
    always_comb begin
        bus.kp_col = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!bus.kp_row[r] && pressed[r*COLS+c]) bus.kp_col[c] = 1'b0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A key flips once its last DEB frame samples all disagree with its state.
    task automatic model_frame(input keys_t bm);
        keys_t      all_pr;
        keys_t      all_rel;
        keys_t      nxt;
        frame_exp_t e;
        hist.push_back(bm);
        if (hist.size() > DEB) void'(hist.pop_front());
        nxt = model_state;
        if (hist.size() == DEB) begin
            all_pr  = '1;
            all_rel = '1;
            foreach (hist[i]) begin
                all_pr  &= hist[i];
                all_rel &= ~hist[i];
            end
            nxt = (model_state | all_pr) & ~all_rel;
        end
        e.state     = nxt;
        e.press     = nxt & ~model_state;
        e.rel       = model_state & ~nxt;
        model_state = nxt;
        exp_q.push_back(e);
    endtask

    task automatic wait_fd(output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!bus.frame_done && cycles < 4 * PERIOD);
        check("frame_done_seen", 64'(bus.frame_done), 64'(1));
    endtask

    task automatic frame(input keys_t bm, output int cycles);
        pressed = bm;
        model_frame(bm);
        bus.scan_en = 1'b1;
        wait_fd(cycles);
    endtask

    // Monitor: gather pulses across a frame and compare at its frame_done.
    initial begin
        keys_t      acc_press;
        keys_t      acc_rel;
        logic       multi;
        frame_exp_t e;
        acc_press = '0;
        acc_rel   = '0;
        multi     = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                acc_press = '0;
                acc_rel   = '0;
                multi     = 1'b0;
            end else begin
                if ((bus.key_press & acc_press) != '0 || (bus.key_release & acc_rel) != '0)
                    multi = 1'b1;
                acc_press |= bus.key_press;
                acc_rel   |= bus.key_release;
                for (int i = 0; i < NK; i++)
                    if (bus.key_press[i]) press_cyc[i] = cyc;
                if (bus.frame_done) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL frame: frame_done with no expected frame (cycle %0d)", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame{multi,press,release,state,any}",
                              64'({multi, acc_press, acc_rel, bus.key_state, bus.any_key}),
                              64'({1'b0, e.press, e.rel, e.state, |e.state}));
                    end
                    acc_press = '0;
                    acc_rel   = '0;
                    multi     = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int              n;
        keys_t           bm;
        logic [ROWS-1:0] exp_row;

        bus.scan_en = 1'b0;
        reset       = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_kp_row", 64'(bus.kp_row), 64'(4'b1111));
        check("reset_keys", 64'({bus.key_state, bus.key_press, bus.key_release}), 64'(0));
        check("reset_any_fd", 64'({bus.any_key, bus.frame_done}), 64'(0));
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_kp_row", 64'(bus.kp_row), 64'(4'b1111));

        // First frame: walk the rows, five cycles each.
        pressed = '0;
        model_frame('0);
        bus.scan_en = 1'b1;
        for (int j = 0; j < PERIOD; j++) begin
            @(negedge clock);
            exp_row = ~(ROWS'(1) << (j / (SETTLE + 1)));
            check("kp_row_walk", 64'(bus.kp_row), 64'(exp_row));
        end
        wait_fd(n);
        frame('0, n);
        check("frame_period", 64'(n), 64'(PERIOD));

        // Row1/col2 held three frames, then released.
        repeat (3) frame(keys_t'(1) << 6, n);
        check("key6_set", 64'({bus.key_state, bus.any_key}), 64'({16'h0040, 1'b1}));
        repeat (3) frame('0, n);
        check("key6_cleared", 64'(bus.key_state), 64'(0));

        // Two-frame hold is a glitch.
        repeat (2) frame(keys_t'(1) << 6, n);
        repeat (3) frame('0, n);
        check("glitch_ignored", 64'(bus.key_state), 64'(0));

        // Opposite corners together.
        repeat (3) frame(keys_t'(16'h8001), n);
        check("corners_set", 64'(bus.key_state), 64'(16'h8001));
        repeat (3) frame('0, n);

        // Same-row keys must pulse in the same cycle.
        for (int i = 0; i < NK; i++) press_cyc[i] = -1;
        repeat (3) frame(keys_t'(16'h000B), n);
        check("row0_press_seen", 64'(press_cyc[0] != -1), 64'(1));
        check("same_row_press_0_1", 64'(press_cyc[1]), 64'(press_cyc[0]));
        check("same_row_press_0_3", 64'(press_cyc[3]), 64'(press_cyc[0]));
        repeat (3) frame('0, n);

        // Randomised sparse key activity.
        bm = '0;
        for (int f = 0; f < 40; f++) begin
            bm = bm ^ keys_t'($urandom & $urandom & $urandom);
            frame(bm, n);
        end
        repeat (3) frame('0, n);

        // Stop scanning mid-frame while key 6 is down.
        bm = keys_t'(1) << 6;
        repeat (3) frame(bm, n);
        pressed = bm;
        model_frame(bm);
        repeat (7) @(negedge clock);
        check("in_row1", 64'(bus.kp_row), 64'(4'b1101));
        bus.scan_en = 1'b0;
        wait_fd(n);
        check("idle_after_frame", 64'(bus.kp_row), 64'(4'b1111));
        n = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clock);
            if (bus.frame_done || bus.kp_row != 4'b1111) n++;
        end
        check("idle_quiet", 64'(n), 64'(0));
        check("idle_hold", 64'(bus.key_state), 64'(model_state));

        // Restart begins at row 0.
        model_frame(bm);
        bus.scan_en = 1'b1;
        @(negedge clock);
        check("restart_row0", 64'(bus.kp_row), 64'(4'b1110));
        wait_fd(n);
        check("restart_period", 64'(n), 64'(PERIOD));

        // Reset in the middle of a frame with key 6 set.
        model_frame(bm);
        repeat (8) @(negedge clock);
        check("key6_before_reset", 64'(bus.key_state[6]), 64'(1));
        reset = 1'b0;
        @(negedge clock);
        check("midreset_kp_row", 64'(bus.kp_row), 64'(4'b1111));
        check("midreset_keys", 64'({bus.key_state, bus.key_press, bus.key_release}), 64'(0));
        check("midreset_any_fd", 64'({bus.any_key, bus.frame_done}), 64'(0));
        bus.scan_en = 1'b0;
        pressed     = '0;
        exp_q.delete();
        hist.delete();
        model_state = '0;
        @(negedge clock);
        check("midreset_no_release", 64'(bus.key_release), 64'(0));
        reset = 1'b1;
        @(negedge clock);
        check("post_reset_idle", 64'(bus.kp_row), 64'(4'b1111));
        frame('0, n);
        frame('0, n);
        check("post_reset_period", 64'(n), 64'(PERIOD));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Parametrised successor to the fixed 2-row keypad decoder used for paddle control.
- Scans a ROWS x COLS active-low key matrix one row at a time and synchronises the column inputs.
- Debounces every key independently and reports a full multi-key pressed bitmap, plus one-cycle press and release event pulses.
- Sits between the board keypad pins and the game control logic, which maps key indices to paddle up/down.

Parameters:
- ROWS, 4, number of matrix rows driven; must be at least 1.
- COLS, 4, number of matrix columns sensed; must be at least 1.
- SETTLE_CYCLES, 4, clock cycles a row is driven before its columns are sampled; must be at least 3 to cover the 2-flop synchroniser.
- DEBOUNCE, 3, consecutive agreeing samples of a key needed to change its state; must be at least 1.
- NKEYS, ROWS*COLS, derived; not overridable.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- scan_en  in  1  enables scanning; sampled only at frame boundaries and in IDLE.
- kp_col  in  COLS  raw column lines, active-low with pull-ups, asynchronous.
- kp_row  out  ROWS  row drive, one-hot active-low; all ones when idle.
- key_state  out  NKEYS  debounced pressed bitmap; bit index = row*COLS + col.
- key_press  out  NKEYS  one-cycle pulse on each debounced 0->1 transition.
- key_release  out  NKEYS  one-cycle pulse on each debounced 1->0 transition.
- any_key  out  1  OR-reduction of key_state.
- frame_done  out  1  one-cycle pulse after the last row of a frame is sampled.

Behaviour:

Reset (reset==0 at a clock edge):
- State IDLE; kp_row all ones.
- key_state, key_press, key_release, any_key and frame_done all 0.
- All debounce counters 0; synchroniser flops set to all ones.
- Reset takes effect mid-frame with no completion.

Synchroniser:
- kp_col passes through 2 flops; raw_press[c] = ~sync_col[c].

FSM states IDLE, DRIVE, SAMPLE:
- IDLE: kp_row all ones. If scan_en==1, go to DRIVE with row index 0, so kp_row[0]=0 next cycle.
- DRIVE: settle counter runs 0..SETTLE_CYCLES-1. At SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (one cycle): update the debounce cells of the current row r from raw_press.
  - If r < ROWS-1: r <= r+1, go to DRIVE.
  - If r == ROWS-1: pulse frame_done. If scan_en==1, r <= 0 and go to DRIVE; otherwise go to IDLE.
- Frame period is ROWS*(SETTLE_CYCLES+1) cycles; 20 cycles at the defaults.
- Deasserting scan_en mid-frame completes the frame and then idles. key_state holds its value while idle.

Debounce cell (per key, updated only in its row's SAMPLE cycle):
- If raw equals state: counter <= 0.
- Else if counter == DEBOUNCE-1: state flips, counter <= 0, and the matching press or release pulse goes high for exactly the next cycle.
- Else: counter <= counter+1.
- Counter width is clog2(DEBOUNCE), minimum 1 bit.
- With DEBOUNCE=1, a key changes on the first differing sample.

Timing and outputs:
- key_state and the pulses are registered; they change on the clock edge that ends SAMPLE.
- Outside that cycle, key_press and key_release are 0.
- Multiple keys, including keys in the same row, may change in the same SAMPLE. No ghost-key suppression; that is the consumer's responsibility.
- A glitch shorter than DEBOUNCE consecutive samples never changes key_state.
- Debounced latency from a stable press is between DEBOUNCE-1 and DEBOUNCE frames, plus the synchroniser.
- any_key is combinational from key_state.

Decomposition:
- Shared package keypad_pkg:
  - scan state enum (IDLE, DRIVE, SAMPLE);
  - key_index(row, col) function;
  - minimum constants MIN_SETTLE=3 and MIN_DEBOUNCE=1, checked by elaboration assertions.
- One natural sub-module: keypad_debounce_cell, holding the state bit, counter and pulse outputs. Instantiate it NKEYS times in a generate loop.

Test Plan (defaults ROWS=4, COLS=4, SETTLE=4, DEBOUNCE=3):
- Reset, then scan_en=1 -> kp_row steps 1110, 1101, 1011, 0111, each for 5 cycles; frame_done pulses every 20 cycles; all key outputs stay 0.
- Hold key row1/col2 (kp_col[2]=0 while kp_row[1]=0) -> key_state[6] and a single key_press[6] pulse within 3 frames; no other bit changes; any_key=1.
- Same key held for only 2 frames -> key_state[6] never rises and no pulse occurs. Held for 3 frames, then released for 3 frames -> exactly one key_press[6] and one key_release[6].
- Press row0/col0 and row3/col3 together -> bits 0 and 15 both set, each with its own single press pulse; keys in the same row changing together pulse in the same cycle.
- Deassert scan_en during row 1 -> the frame completes with a frame_done pulse, kp_row goes to 1111, and key_state holds. Reassert -> scanning restarts at row 0.
- Assert reset mid-frame with key_state[6]=1 -> on the next cycle kp_row=1111, key_state=0 and no release pulse.
